unary_op_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bit combinational unary-gate block. It applies one of eight runtime-selectable unary operators to a WIDTH-bit operand. Each transaction has a valid/ready handshake on input and output, and the block accepts one transaction per cycle. It serves as the unary-operator leaf used by the dataflow test designs, which exercise propagation through registered, back-pressured paths.

---
 rtl/unary_op_pipe.sv | 174 +++++++++++++++++
 tb/tb_unary_op_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_op_pipe.sv
// -----------------------------------------------------------------------------
// unary_op_pipe
//
// Two-stage, valid/ready pipelined unary operator. S1 registers the operand and
// operator; S2 registers the computed result and operator. Accepts one
// transaction per clock with a latency of two cycles when not back-pressured.
//
// Operators (i_in_op):
//   0 NOT   : ~x
//   1 POS   : x
//   2 NEG   : two's complement of x
//   3 RAND  : &x        (bit 0, zero-extended)
//   4 ROR   : |x        (bit 0, zero-extended)
//   5 RXOR  : ^x        (bit 0, zero-extended)
//   6 RXNOR : ~^x       (bit 0, zero-extended)
//   7 LNOT  : x == 0    (bit 0, zero-extended)
//
// Ports:
//   clk           clock, rising-edge
//   rst_n         asynchronous active-low reset
//   i_in_valid    input transaction valid
//   o_in_ready    block can accept this cycle (combinational)
//   i_in_data     operand, WIDTH bits
//   i_in_op       operator select, 3 bits
//   o_out_valid   result valid
//   i_out_ready   downstream accepts this cycle
//   o_out_data    result, WIDTH bits
//   o_out_op      operator that produced o_out_data
//   o_stat_count  saturating completed-transaction count, COUNT_W bits
//                 (present only when UNARY_OP_STATS_EN is defined)
//
// Build option:
//   UNARY_OP_STATS_EN  adds o_stat_count and its counter.
// -----------------------------------------------------------------------------
module unary_op_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_in_data,
    input  logic [2:0]         i_in_op,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_out_data,
    output logic [2:0]         o_out_op
`ifdef UNARY_OP_STATS_EN
    ,
    output logic [COUNT_W-1:0] o_stat_count
`endif
);

    typedef enum logic [2:0] {
        OP_NOT   = 3'd0,
        OP_POS   = 3'd1,
        OP_NEG   = 3'd2,
        OP_RAND  = 3'd3,
        OP_ROR   = 3'd4,
        OP_RXOR  = 3'd5,
        OP_RXNOR = 3'd6,
        OP_LNOT  = 3'd7
    } op_e;

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_data;
    logic [2:0]         r_s1_op;

    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_data;
    logic [2:0]         r_s2_op;

    logic               w_in_accept;
    logic               w_out_done;
    logic               w_s2_load;
    logic [WIDTH-1:0]   w_result;

    // ------------------------------------------------------------------------
    // Handshake and advance control. There is no skid buffer: ready ripples
    // combinationally from the output back to the input when both stages are
    // occupied.
    // ------------------------------------------------------------------------
    assign w_out_done  = r_s2_valid && i_out_ready;
    assign w_s2_load   = r_s1_valid && (!r_s2_valid || i_out_ready);
    assign o_in_ready  = !r_s1_valid || !r_s2_valid || i_out_ready;
    assign w_in_accept = i_in_valid && o_in_ready;

    // ------------------------------------------------------------------------
    // Operator evaluation on the S1 contents. Single-bit results land in bit 0
    // with the upper bits left at the zero default.
    // ------------------------------------------------------------------------
    always_comb begin
        w_result = '0;
        case (op_e'(r_s1_op))
            OP_NOT:   w_result    = ~r_s1_data;
            OP_POS:   w_result    = r_s1_data;
            OP_NEG:   w_result    = ~r_s1_data + WIDTH'(1);
            OP_RAND:  w_result[0] = &r_s1_data;
            OP_ROR:   w_result[0] = |r_s1_data;
            OP_RXOR:  w_result[0] = ^r_s1_data;
            OP_RXNOR: w_result[0] = ~^r_s1_data;
            OP_LNOT:  w_result[0] = (r_s1_data == '0);
            default:  w_result    = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage 1: operand/op capture.
    // S1 empties when its contents move to S2 and nothing new arrives.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= '0;
        end else begin
            if (w_in_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= i_in_data;
                r_s1_op    <= i_in_op;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: result/op register driving the output port. Holds while the
    // downstream stalls; a load and a completion in the same cycle keep it
    // occupied.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_op    <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= w_result;
                r_s2_op    <= r_s1_op;
            end else if (w_out_done) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_s2_valid;
    assign o_out_data  = r_s2_data;
    assign o_out_op    = r_s2_op;

`ifdef UNARY_OP_STATS_EN
    // ------------------------------------------------------------------------
    // Completed-transaction counter, saturating at all-ones.
    // ------------------------------------------------------------------------
    logic [COUNT_W-1:0] r_stat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_count <= '0;
        end else if (w_out_done && (r_stat_count != '1)) begin
            r_stat_count <= r_stat_count + COUNT_W'(1);
        end
    end

    assign o_stat_count = r_stat_count;
`else
    // COUNT_W only sizes the statistics counter; nothing to build here.
    if (COUNT_W < 1) begin : g_count_w_unused
    end
`endif

endmodule

// File: tb/tb_unary_op_pipe.sv
module tb_unary_op_pipe;

    localparam int W  = 8;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [W-1:0] i_in_data;
    logic [2:0]   i_in_op;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [W-1:0] o_out_data;
    logic [2:0]   o_out_op;
`ifdef UNARY_OP_STATS_EN
    logic [CW-1:0] o_stat_count;
`endif

    unary_op_pipe #(.WIDTH(W), .COUNT_W(CW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_data    (i_in_data),
        .i_in_op      (i_in_op),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_out_op     (o_out_op)
`ifdef UNARY_OP_STATS_EN
        ,
        .o_stat_count (o_stat_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Driven values applied at the start of each cycle.
    logic         drv_valid = 1'b0;
    logic [W-1:0] drv_data  = '0;
    logic [2:0]   drv_op    = '0;
    logic         drv_ready = 1'b1;

    // Observations from the most recent cycle.
    logic         s_acc, s_cmp, s_ovalid, s_irdy;
    logic [W-1:0] s_odata;
    logic [2:0]   s_oop;

    // Reference model: in-flight transactions in arrival order.
    int exp_data_q[$];
    int exp_op_q[$];
    int n_done = 0;
    int cyc_n  = 0;

    // Captured completions for ordering / gap checks.
    int cap_d[$];
    int cap_op[$];
    int cap_t[$];

    logic [W-1:0] neg_in  [3] = '{8'h01, 8'h00, 8'h80};
    logic [W-1:0] neg_exp [3] = '{8'hFF, 8'h00, 8'h80};
    logic [W-1:0] bp_exp  [3] = '{8'h11, 8'h22, 8'h33};
    int           stat_exp[5] = '{1, 2, 3, 3, 3};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Operator semantics expressed arithmetically on an 8-bit operand.
    function automatic int ref_op(input int op, input int x);
        int ones;
        ones = $countones(x);
        case (op)
            0:       return 255 - x;
            1:       return x;
            2:       return (256 - x) % 256;
            3:       return (x == 255) ? 1 : 0;
            4:       return (x != 0) ? 1 : 0;
            5:       return ones % 2;
            6:       return 1 - (ones % 2);
            default: return (x == 0) ? 1 : 0;
        endcase
    endfunction

    // One clock cycle: apply drive, observe, update the model, then clock.
    task automatic cycle();
        @(negedge clk);
        i_in_valid  = drv_valid;
        i_in_data   = drv_data;
        i_in_op     = drv_op;
        i_out_ready = drv_ready;
        #1;
        s_irdy   = o_in_ready;
        s_ovalid = o_out_valid;
        s_odata  = o_out_data;
        s_oop    = o_out_op;
        s_acc    = drv_valid && o_in_ready;
        s_cmp    = o_out_valid && drv_ready;

        check_val("in_ready", o_in_ready, ((exp_data_q.size() < 2) || drv_ready) ? 1 : 0);
`ifdef UNARY_OP_STATS_EN
        check_val("stat_count", o_stat_count, (n_done > 3) ? 3 : n_done);
`endif
        if (exp_data_q.size() == 0) begin
            check_val("idle_out_valid", o_out_valid, 0);
        end else if (o_out_valid) begin
            check_val("out_data", o_out_data, exp_data_q[0]);
            check_val("out_op", o_out_op, exp_op_q[0]);
        end

        if (s_cmp && exp_data_q.size() != 0) begin
            void'(exp_data_q.pop_front());
            void'(exp_op_q.pop_front());
            n_done++;
            cap_d.push_back(int'(o_out_data));
            cap_op.push_back(int'(o_out_op));
            cap_t.push_back(cyc_n);
        end
        if (s_acc) begin
            exp_data_q.push_back(ref_op(int'(drv_op), int'(drv_data)));
            exp_op_q.push_back(int'(drv_op));
        end
        cyc_n++;
        @(posedge clk);
    endtask

    // Asynchronous reset for one cycle with in_valid held high throughout.
    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        i_in_valid  = 1'b1;
        i_in_data   = W'($urandom);
        i_in_op     = 3'($urandom);
        i_out_ready = 1'b1;
        #1;
        check_val("rst_out_valid", o_out_valid, 0);
        check_val("rst_out_data", o_out_data, 0);
        check_val("rst_out_op", o_out_op, 0);
        check_val("rst_in_ready", o_in_ready, 1);
`ifdef UNARY_OP_STATS_EN
        check_val("rst_stat", o_stat_count, 0);
`endif
        exp_data_q.delete();
        exp_op_q.delete();
        n_done = 0;
        @(negedge clk);
        i_in_valid = 1'b0;
        drv_valid  = 1'b0;
        rst_n      = 1'b1;
    endtask

    // Single transaction into an empty pipe; checks latency and result.
    task automatic send_one(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] exp);
        int n;
        drv_ready = 1'b1;
        drv_valid = 1'b1;
        drv_op    = op;
        drv_data  = d;
        cycle();
        check_val("one_accept", s_acc, 1);
        drv_valid = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_ovalid && n < 10);
        check_val("one_latency", n, 2);
        check_val("one_result", s_odata, exp);
        check_val("one_op", s_oop, op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_in_op     = '0;
        i_out_ready = 1'b1;

        // Reset, then NOT of 0x5A.
        apply_reset();
        send_one(3'd0, 8'h5A, 8'hA5);

        // NEG boundaries back-to-back.
        cap_d.delete(); cap_op.delete(); cap_t.delete();
        drv_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_valid = 1'b1;
            drv_op    = 3'd2;
            drv_data  = neg_in[i];
            cycle();
            check_val("neg_accept", s_acc, 1);
        end
        drv_valid = 1'b0;
        n = 0;
        while (cap_d.size() < 3 && n < 10) begin
            cycle();
            n++;
        end
        check_val("neg_count", cap_d.size(), 3);
        if (cap_d.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_val("neg_data", cap_d[i], neg_exp[i]);
                check_val("neg_op", cap_op[i], 2);
            end
            check_val("neg_gap01", cap_t[1] - cap_t[0], 1);
            check_val("neg_gap12", cap_t[2] - cap_t[1], 1);
        end

        // Reductions.
        send_one(3'd3, 8'hFF, 8'h01);
        send_one(3'd3, 8'hFE, 8'h00);
        send_one(3'd5, 8'h07, 8'h01);
        send_one(3'd6, 8'h07, 8'h00);
        send_one(3'd7, 8'h00, 8'h01);
        send_one(3'd4, 8'h00, 8'h00);

        // Backpressure.
        cap_d.delete(); cap_op.delete(); cap_t.delete();
        drv_ready = 1'b0;
        drv_op    = 3'd1;
        drv_valid = 1'b1;
        drv_data  = 8'h11; cycle(); check_val("bp_acc11", s_acc, 1);
        drv_data  = 8'h22; cycle(); check_val("bp_acc22", s_acc, 1);
        drv_data  = 8'h33; cycle(); check_val("bp_acc33", s_acc, 0);
        check_val("bp_in_ready", s_irdy, 0);
        repeat (3) cycle();
        check_val("bp_hold_valid", s_ovalid, 1);
        check_val("bp_hold_data", s_odata, 8'h11);
        check_val("bp_still_blocked", s_acc, 0);
        drv_ready = 1'b1;
        cycle();
        check_val("bp_acc33_late", s_acc, 1);
        drv_valid = 1'b0;
        n = 0;
        while (cap_d.size() < 3 && n < 10) begin
            cycle();
            n++;
        end
        check_val("bp_count", cap_d.size(), 3);
        if (cap_d.size() == 3) begin
            for (int i = 0; i < 3; i++) check_val("bp_order", cap_d[i], bp_exp[i]);
            check_val("bp_gap01", cap_t[1] - cap_t[0], 1);
            check_val("bp_gap12", cap_t[2] - cap_t[1], 1);
        end

        // Reset mid-flight.
        drv_ready = 1'b0;
        drv_valid = 1'b1;
        drv_op    = 3'd0;
        drv_data  = 8'hAA; cycle(); check_val("mf_acc0", s_acc, 1);
        drv_data  = 8'hBB; cycle(); check_val("mf_acc1", s_acc, 1);
        drv_valid = 1'b0;
        apply_reset();
        drv_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            cycle();
            seen = seen | s_ovalid;
        end
        check_val("mf_flushed", seen, 0);
        send_one(3'd1, 8'h3C, 8'h3C);

`ifdef UNARY_OP_STATS_EN
        // Saturating counter with COUNT_W=2.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            send_one(3'd1, W'(k + 1), W'(k + 1));
            @(negedge clk);
            #1;
            check_val("stat_seq", o_stat_count, stat_exp[k]);
        end
        apply_reset();
`endif

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_ready = ($urandom_range(0, 2) != 0);
            drv_op    = 3'($urandom);
            drv_data  = W'($urandom);
            cycle();
        end
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        n = 0;
        while (exp_data_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        check_val("drain_empty", exp_data_q.size(), 0);
        cycle();
        check_val("drain_idle", s_ovalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
